// File: rtl/bullet_defs_pkg.sv
// Shared bullet-table layout: table base, record offsets, direction bit indices,
// screen limits and the mover FSM encoding.
package bullet_defs;

  localparam logic [7:0] BASE      = 8'd192;
  localparam int         SLOTS     = 16;
  localparam logic [3:0] LAST_SLOT = 4'(SLOTS - 1);
  localparam int         STEP      = 2;
  localparam int         XMAX      = 159;
  localparam int         YMAX      = 119;

  localparam logic [1:0] OFF_STAT = 2'd0;
  localparam logic [1:0] OFF_DIR  = 2'd1;
  localparam logic [1:0] OFF_X    = 2'd2;
  localparam logic [1:0] OFF_Y    = 2'd3;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    S_STAT = 4'd1,
    S_DIR  = 4'd2,
    S_X    = 4'd3,
    S_Y    = 4'd4,
    S_CALC = 4'd5,
    S_WX   = 4'd6,
    S_WY   = 4'd7,
    S_KILL = 4'd8,
    S_NEXT = 4'd9,
    S_DONE = 4'd10
  } state_t;

  // Byte address of one field of one record (4 bytes per record).
  function automatic logic [7:0] rec_addr(input logic [3:0] slot, input logic [1:0] off);
    return BASE + {2'b00, slot, off};
  endfunction

endpackage

// File: rtl/bullet_step.sv
// Combinational one-step bullet motion with off-screen detection; shared with the enemy-bullet mover.
module bullet_step #(
  parameter int STEP = 2,
  parameter int XMAX = 159,
  parameter int YMAX = 119
) (
  input  logic [7:0] i_x,
  input  logic [7:0] i_y,
  input  logic [3:0] i_dir,
  output logic [7:0] o_nx,
  output logic [7:0] o_ny,
  output logic       o_kill
);
  import bullet_defs::*;

  logic       w_up, w_down, w_left, w_right;
  logic [8:0] w_x_plus, w_y_plus;

  // An opposing pair cancels: no motion, so no exit, on that axis.
  assign w_up    = i_dir[DIR_UP]    & ~i_dir[DIR_DOWN];
  assign w_down  = i_dir[DIR_DOWN]  & ~i_dir[DIR_UP];
  assign w_left  = i_dir[DIR_LEFT]  & ~i_dir[DIR_RIGHT];
  assign w_right = i_dir[DIR_RIGHT] & ~i_dir[DIR_LEFT];

  assign w_x_plus = {1'b0, i_x} + 9'(STEP);
  assign w_y_plus = {1'b0, i_y} + 9'(STEP);

  always_comb begin
    o_nx = i_x;
    o_ny = i_y;
    if (w_left)  o_nx = i_x - 8'(STEP);
    if (w_right) o_nx = i_x + 8'(STEP);
    if (w_up)    o_ny = i_y - 8'(STEP);
    if (w_down)  o_ny = i_y + 8'(STEP);
  end

  assign o_kill = (w_left  && ({1'b0, i_x} < 9'(STEP))) ||
                  (w_right && (w_x_plus > 9'(XMAX)))    ||
                  (w_up    && ({1'b0, i_y} < 9'(STEP))) ||
                  (w_down  && (w_y_plus > 9'(YMAX)));

endmodule

// File: rtl/player_bullet_mover.sv
// Scans the 16-slot player-bullet table on each go, stepping live bullets or retiring off-screen ones.
// Define BULLET_COUNT_EN to add active_count (live bullets after the last scan).
module player_bullet_mover
  import bullet_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       mem_grant,
  input  logic [7:0] DataOut,
  output logic [7:0] address,
  output logic [7:0] DataIn,
  output logic       writeEn,
  output logic       busy,
  output logic       done,
`ifdef BULLET_COUNT_EN
  output logic [4:0] active_count,
`endif
  output state_t     o_dbg_state
);

  state_t     r_state, w_next;
  logic [3:0] r_slot;
  logic [3:0] r_dir;
  logic [7:0] r_x, r_nx, r_ny;
  logic [7:0] w_nx, w_ny;
  logic       w_kill, w_start;

  assign w_start     = (r_state == IDLE) && go && mem_grant;
  assign o_dbg_state = r_state;

  // y is taken straight off the read port in S_CALC, so the step result is valid there.
  bullet_step #(.STEP(STEP), .XMAX(XMAX), .YMAX(YMAX)) u_step (
    .i_x    (r_x),
    .i_y    (DataOut),
    .i_dir  (r_dir),
    .o_nx   (w_nx),
    .o_ny   (w_ny),
    .o_kill (w_kill)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_slot  <= '0;
      r_dir   <= '0;
      r_x     <= '0;
      r_nx    <= '0;
      r_ny    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE:    if (w_start) r_slot <= '0;
        S_X:     r_dir <= DataOut[3:0];
        S_Y:     r_x   <= DataOut;
        S_CALC: begin
          r_nx <= w_nx;
          r_ny <= w_ny;
        end
        S_NEXT:  if (r_slot != LAST_SLOT && mem_grant) r_slot <= r_slot + 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next  = r_state;
    address = rec_addr(r_slot, OFF_STAT);
    DataIn  = '0;
    writeEn = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (r_state)
      IDLE: begin
        address = BASE;
        busy    = 1'b0;
        if (w_start) w_next = S_STAT;
      end
      S_STAT: w_next = S_DIR;
      S_DIR: begin
        address = rec_addr(r_slot, OFF_DIR);
        w_next  = DataOut[0] ? S_X : S_NEXT;
      end
      S_X: begin
        address = rec_addr(r_slot, OFF_X);
        w_next  = S_Y;
      end
      S_Y: begin
        address = rec_addr(r_slot, OFF_Y);
        w_next  = S_CALC;
      end
      S_CALC: begin
        address = rec_addr(r_slot, OFF_Y);
        w_next  = w_kill ? S_KILL : S_WX;
      end
      S_WX: begin
        address = rec_addr(r_slot, OFF_X);
        DataIn  = r_nx;
        writeEn = 1'b1;
        w_next  = S_WY;
      end
      S_WY: begin
        address = rec_addr(r_slot, OFF_Y);
        DataIn  = r_ny;
        writeEn = 1'b1;
        w_next  = S_NEXT;
      end
      S_KILL: begin
        writeEn = 1'b1;
        w_next  = S_NEXT;
      end
      // The grant is only checked between slots, so a record is never split.
      S_NEXT: begin
        if (r_slot == LAST_SLOT) w_next = S_DONE;
        else if (mem_grant)      w_next = S_STAT;
      end
      S_DONE: begin
        address = BASE;
        busy    = 1'b0;
        done    = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

`ifdef BULLET_COUNT_EN
  logic [4:0] r_cnt, r_active_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt          <= '0;
      r_active_count <= '0;
    end else begin
      if (w_start)                r_cnt <= '0;
      else if (r_state == S_WX)   r_cnt <= r_cnt + 5'd1;
      if (r_state == S_DONE)      r_active_count <= r_cnt;
    end
  end

  assign active_count = r_active_count;
`endif

endmodule

// File: tb/tb_player_bullet_mover.sv
// Directed bench for player_bullet_mover with a synchronous-read RAM model and a write log.
module tb_player_bullet_mover;
  import bullet_defs::*;

  logic       clk = 1'b0;
  logic       reset, go, mem_grant;
  logic [7:0] DataOut, address, DataIn;
  logic       writeEn, busy, done;
  state_t     dbg_state;
`ifdef BULLET_COUNT_EN
  logic [4:0] active_count;
`endif

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  player_bullet_mover dut (
    .clk          (clk),
    .reset        (reset),
    .go           (go),
    .mem_grant    (mem_grant),
    .DataOut      (DataOut),
    .address      (address),
    .DataIn       (DataIn),
    .writeEn      (writeEn),
    .busy         (busy),
    .done         (done),
`ifdef BULLET_COUNT_EN
    .active_count (active_count),
`endif
    .o_dbg_state  (dbg_state)
  );

  // ---------------- RAM model + write log ----------------
  logic [7:0]  mem [0:255];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_addr = '0;
  logic [7:0]  bd_data = '0;
  logic [15:0] wlog [0:255];
  int          wr_n = 0;

  always @(posedge clk) begin
    DataOut <= mem[address];
    if (writeEn)    mem[address] <= DataIn;
    else if (bd_we) mem[bd_addr] <= bd_data;
  end

  always @(negedge clk) begin
    if (writeEn && wr_n < 256) begin
      wlog[wr_n] <= {address, DataIn};
      wr_n       <= wr_n + 1;
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  task automatic clear_table();
    for (int a = 192; a < 256; a++) poke(8'(a), 8'd0);
  endtask

  task automatic put_rec(input int slot, input logic [7:0] st, input logic [7:0] dir,
                         input logic [7:0] x, input logic [7:0] y);
    poke(8'(192 + 4 * slot),     st);
    poke(8'(192 + 4 * slot + 1), dir);
    poke(8'(192 + 4 * slot + 2), x);
    poke(8'(192 + 4 * slot + 3), y);
  endtask

  // Leaves the bench at the negedge of cycle 1 (first S_STAT).
  task automatic start_scan();
    @(negedge clk);
    mem_grant = 1'b1;
    go        = 1'b1;
    @(negedge clk);
    go        = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int cyc;
    cyc = 1;
    while (!done && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, "_done_single"}, 32'(done), 32'd0);
    chk({tag, "_idle_after"}, 32'(dbg_state), 32'(IDLE));
  endtask

  task automatic check_writes(input string tag, input int base);
    int n;
    n = wr_n - base;
    chk({tag, "_wr_count"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      chk({tag, "_wr"}, 32'(wlog[base + i]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int  base;
    bit  found;
    reset     = 1'b1;
    go        = 1'b0;
    mem_grant = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state",   32'(dbg_state), 32'(IDLE));
    chk("rst_address", 32'(address),   32'd192);
    chk("rst_datain",  32'(DataIn),    32'd0);
    chk("rst_we",      32'(writeEn),   32'd0);
    chk("rst_busy",    32'(busy),      32'd0);
    chk("rst_done",    32'(done),      32'd0);
`ifdef BULLET_COUNT_EN
    chk("rst_count",   32'(active_count), 32'd0);
`endif
    reset = 1'b0;
    clear_table();

    // Empty table: 16 x 3 cycles, done at cycle 49, no writes.
    base = wr_n;
    start_scan();
    chk("empty_busy", 32'(busy), 32'd1);
    chk("empty_state", 32'(dbg_state), 32'(S_STAT));
    wait_done("empty", 49);
    check_writes("empty", base);
`ifdef BULLET_COUNT_EN
    chk("empty_count", 32'(active_count), 32'd0);
`endif

    // Slot 0 moving right: 8 cycles for slot 0, done at 54.
    put_rec(0, 8'd1, 8'b1000, 8'd10, 8'd20);
    base = wr_n;
    exp_q.push_back({8'd194, 8'd12});
    exp_q.push_back({8'd195, 8'd20});
    start_scan();
    wait_done("right", 54);
    check_writes("right", base);
    chk("right_mem_x", 32'(mem[194]), 32'd12);
    chk("right_mem_y", 32'(mem[195]), 32'd20);
`ifdef BULLET_COUNT_EN
    chk("right_count", 32'(active_count), 32'd1);
`endif

    // Mixed table: kills, boundaries, dir=0, opposing pairs, status bit 0 clear.
    clear_table();
    put_rec(1,  8'd2, 8'b1000,   8'd10,  8'd10);
    put_rec(5,  8'd1, 8'b1000,   8'd158, 8'd50);
    put_rec(7,  8'd1, 8'b0000,   8'd80,  8'd60);
    put_rec(9,  8'd1, 8'b0101,   8'd50,  8'd40);
    put_rec(10, 8'd1, 8'b1010,   8'd157, 8'd117);
    put_rec(11, 8'd1, 8'b0010,   8'd20,  8'd118);
    put_rec(12, 8'd1, 8'b0001,   8'd5,   8'd2);
    put_rec(13, 8'd1, 8'b1101,   8'd30,  8'd10);
    put_rec(15, 8'd1, 8'b0111,   8'd1,   8'd60);
    base = wr_n;
    exp_q.push_back({8'd212, 8'd0});
    exp_q.push_back({8'd222, 8'd80});
    exp_q.push_back({8'd223, 8'd60});
    exp_q.push_back({8'd230, 8'd48});
    exp_q.push_back({8'd231, 8'd38});
    exp_q.push_back({8'd234, 8'd159});
    exp_q.push_back({8'd235, 8'd119});
    exp_q.push_back({8'd236, 8'd0});
    exp_q.push_back({8'd242, 8'd5});
    exp_q.push_back({8'd243, 8'd0});
    exp_q.push_back({8'd246, 8'd30});
    exp_q.push_back({8'd247, 8'd8});
    exp_q.push_back({8'd252, 8'd0});
    start_scan();
    wait_done("mixed", 86);
    check_writes("mixed", base);
    chk("kill5_x_stale",  32'(mem[214]), 32'd158);
    chk("kill5_y_stale",  32'(mem[215]), 32'd50);
    chk("kill15_status",  32'(mem[252]), 32'd0);
    chk("kill15_x_stale", 32'(mem[254]), 32'd1);
    chk("inactive1_x",    32'(mem[198]), 32'd10);
`ifdef BULLET_COUNT_EN
    chk("mixed_count", 32'(active_count), 32'd5);
`endif

    // go without grant is dropped, not queued.
    clear_table();
    put_rec(2, 8'd1, 8'b1000, 8'd10, 8'd10);
    put_rec(3, 8'd1, 8'b0001, 8'd20, 8'd20);
    put_rec(4, 8'd1, 8'b0100, 8'd30, 8'd30);
    mem_grant = 1'b0;
    go        = 1'b1;
    repeat (3) @(negedge clk);
    chk("nogrant_state", 32'(dbg_state), 32'(IDLE));
    chk("nogrant_busy",  32'(busy),      32'd0);
    go        = 1'b0;
    mem_grant = 1'b1;
    @(negedge clk);
    chk("nogrant_noqueue", 32'(dbg_state), 32'(IDLE));

    // Grant withdrawn after slot 3; go during the scan must be ignored.
    base = wr_n;
    exp_q.push_back({8'd202, 8'd12});
    exp_q.push_back({8'd203, 8'd10});
    exp_q.push_back({8'd206, 8'd20});
    exp_q.push_back({8'd207, 8'd18});
    exp_q.push_back({8'd210, 8'd28});
    exp_q.push_back({8'd211, 8'd30});
    start_scan();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (dbg_state == S_WY && address == 8'd207) found = 1'b1;
      else @(negedge clk);
    end
    chk("hold_reach_slot3", 32'(found), 32'd1);
    mem_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      go = 1'b1;
      chk("hold_state", 32'(dbg_state), 32'(S_NEXT));
      chk("hold_addr",  32'(address),   32'd204);
      chk("hold_busy",  32'(busy),      32'd1);
    end
    mem_grant = 1'b1;
    @(negedge clk);
    chk("resume_state", 32'(dbg_state), 32'(S_STAT));
    chk("resume_addr",  32'(address),   32'd208);
    go = 1'b0;
    wait_done("hold", 42);
    check_writes("hold", base);
`ifdef BULLET_COUNT_EN
    chk("hold_count", 32'(active_count), 32'd3);
`endif

    // Reset while writing x.
    clear_table();
    put_rec(0, 8'd1, 8'b1000, 8'd10, 8'd20);
    start_scan();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (dbg_state == S_WX) found = 1'b1;
      else @(negedge clk);
    end
    chk("rst_mid_reach_wx", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_mid_we",    32'(writeEn),   32'd0);
    chk("rst_mid_addr",  32'(address),   32'd192);
    chk("rst_mid_busy",  32'(busy),      32'd0);
    chk("rst_mid_x_kept", 32'(mem[194]), 32'd10);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
